demux1to4_stream: RTL
=====================

Name: demux1to4_stream

Overview:
Registered 1-to-4 stream demultiplexer; the distribution-side counterpart of the 4-to-1 gate mux. One valid/ready input stream is steered by a 2-bit sel into one of four independent output channels. Each channel has a 1-entry output register and its own valid/ready handshake, plus a per-channel transfer counter. It sits between a single producer and four consumers in the lecture datapath.

Parameters:
WIDTH, 8, data width of input and of each output channel
CNT_W, 8, width of each per-channel transfer counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  input payload
in_sel  input  2  destination channel, 0..3
in_valid  input  1  producer has a word
in_ready  output  1  block accepts the word this cycle
out_data  output  4*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH]
out_valid  output  4  channel k register holds an unconsumed word
out_ready  input  4  consumer k accepts this cycle
cnt  output  4*CNT_W  channel k transfer count at bits [k*CNT_W +: CNT_W]
cnt_clr  input  1  synchronous clear of all counters

Behaviour:
- Reset: rst_n low asynchronously forces out_valid=4'b0000, out_data=0, cnt=0. Reset is released synchronously to clk by the environment. Reset mid-transfer discards all held words with no output handshake.
- Accept: input transfer occurs when in_valid && in_ready at a rising edge.
- in_ready = !out_valid[in_sel] || out_ready[in_sel]. This is combinational, from out_ready, out_valid and in_sel. in_ready does not depend on in_valid.
- in_data and in_sel are sampled only at an accepted edge. They need not be held stable while in_ready is low. Changing in_sel while stalled redirects the pending word, which is legal.
- Latency: a word accepted at edge N is on out_data[k] with out_valid[k]=1 after edge N. Latency is 1 cycle.
- Output transfer on channel k: out_valid[k] && out_ready[k] at a rising edge.
- Channel k update per edge:
  - load (accept with in_sel==k): out_data[k] is set to in_data and out_valid[k] is set to 1. This applies even when channel k pops on the same edge, giving full throughput of 1 word/cycle per channel.
  - pop only: out_valid[k] is cleared to 0. out_data[k] holds its last value.
  - neither: the channel holds.
- Channels are fully independent. A stalled channel never blocks words addressed to other channels.
- Channels ignore out_ready[k] when out_valid[k]=0.
- out_valid[k], once set, stays 1 until popped. out_data[k] is stable while out_valid[k]=1 and not popped.
- Counter k increments by 1 on each output transfer of channel k. It is modulo 2^CNT_W, so it wraps from all-ones to 0.
- cnt_clr=1 sets all counters to 0 at the edge. Clear wins over a simultaneous increment, so the result is 0.
- No combinational path from in_valid or in_data to any output.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with channel 2 full -> out_valid=0000, cnt=0 immediately, without waiting for a clk edge. After release, in_ready=1 for any sel.
- Routing: WIDTH=8, all out_ready=1. Send 0xA0,0xB1,0xC2,0xD3 with sel 0,1,2,3 on consecutive cycles -> each appears on its channel one cycle later with out_valid one-hot for one cycle. cnt ends at 1,1,1,1.
- Backpressure: out_ready[1]=0. Send 0x11 then 0x22 to sel=1 -> 0x11 held, in_ready=0 while sel=1. Switch sel=3 with 0x33 -> accepted. Raise out_ready[1] -> 0x11 pops, 0x22 accepted the same edge, and 0x22 is valid next cycle.
- Throughput: sel fixed 0, in_valid and out_ready[0] high for 10 cycles -> 10 words in order, in_ready constantly 1, cnt[0]=10.
- Wrap/clear: CNT_W=8. 256 transfers on channel 2 -> cnt[2]=0. Then 3 transfers -> 3. Assert cnt_clr with a concurrent transfer -> all counters 0.
- Hold: pop channel 0 with no new load -> out_valid[0]=0 and out_data[0] retains its last value.

Source files
------------

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer. One valid/ready input is steered by in_sel
// into four independent single-entry output channels, and each channel has its own transfer counter.
module demux1to4_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*CNT_W-1:0] cnt,
  input  logic               cnt_clr
);

  logic [WIDTH-1:0] data_r [4];
  logic [3:0]       valid_r;
  logic [CNT_W-1:0] cnt_r [4];
  logic [3:0]       sel_hot_s;
  logic [3:0]       load_s;
  logic [3:0]       pop_s;
  logic             ready_s;

  // Destination decode of in_sel
  always_comb begin
    sel_hot_s = 4'b0000;
    case (in_sel)
      2'd0:    sel_hot_s = 4'b0001;
      2'd1:    sel_hot_s = 4'b0010;
      2'd2:    sel_hot_s = 4'b0100;
      2'd3:    sel_hot_s = 4'b1000;
      default: sel_hot_s = 4'b0000;
    endcase
  end

  // The addressed channel can take a word when empty or draining on this same edge
  always_comb begin
    ready_s = ~valid_r[in_sel] | out_ready[in_sel];
    pop_s   = valid_r & out_ready;
    if (in_valid && ready_s) begin
      load_s = sel_hot_s;
    end else begin
      load_s = 4'b0000;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = valid_r;

  // Channel registers: a load takes priority over a pop, which keeps full throughput
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load_s[k]) begin
          data_r[k]  <= in_data;
          valid_r[k] <= 1'b1;
        end else if (pop_s[k]) begin
          valid_r[k] <= 1'b0;
        end else begin
          valid_r[k] <= valid_r[k];
        end
      end
    end
  end

  // Per-channel output transfer counters; a clear overrides a simultaneous increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (cnt_clr) begin
          cnt_r[k] <= '0;
        end else if (pop_s[k]) begin
          cnt_r[k] <= cnt_r[k] + CNT_W'(1'b1);
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign out_data[g*WIDTH +: WIDTH] = data_r[g];
    assign cnt[g*CNT_W +: CNT_W]      = cnt_r[g];
  end

endmodule
